// File: rtl/sprite_rom_arbiter.sv
// Sprite-RAM read-port arbiter: requester 0 has fixed priority, 1..N_REQ-1 are
// served round-robin, and a requester that has waited MAX_WAIT cycles preempts 0.
// Returned data is tagged with the requester index and arrives in grant order.
module sprite_rom_arbiter #(
  parameter int N_REQ    = 9,
  parameter int ID_W     = 4,
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 9,
  parameter int RAM_LAT  = 1,
  parameter int MAX_WAIT = 7
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        gnt,
  output logic                    ram_rd,
  output logic [ADDR_W-1:0]       ram_addr,
  input  logic [DATA_W-1:0]       ram_data,
  output logic                    rd_valid,
  output logic [ID_W-1:0]         rd_id,
  output logic [DATA_W-1:0]       rd_data
);

  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_SAT = CW'(MAX_WAIT);

  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]     wait_q [1:N_REQ-1];
  logic [CW-1:0]     wait_d [1:N_REQ-1];
  logic              gnt_any;
  logic [ID_W-1:0]   win_id;
  logic [ID_W:0]     rr_sum;
  logic [ID_W-1:0]   rr_idx;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              pv_q  [0:RAM_LAT];
  logic [ID_W-1:0]   pid_q [0:RAM_LAT];
  logic              rd_valid_q;
  logic [ID_W-1:0]   rd_id_q;
  logic [DATA_W-1:0] rd_data_q;

  // Winner selection: starved lowest index, then requester 0, then round-robin from rr_ptr.
  always_comb begin
    gnt_any = 1'b0;
    win_id  = '0;
    rr_sum  = '0;
    rr_idx  = '0;
    for (int unsigned k = 1; k < N_REQ; k++) begin
      if (!gnt_any && req[k] && (wait_q[k] >= WAIT_SAT)) begin
        gnt_any = 1'b1;
        win_id  = ID_W'(k);
      end
    end
    if (!gnt_any && req[0]) begin
      gnt_any = 1'b1;
      win_id  = '0;
    end
    // Wider sum avoids overflow before folding back into 1..N_REQ-1.
    for (int unsigned off = 0; off < N_REQ - 1; off++) begin
      rr_sum = {1'b0, rr_ptr_q} + (ID_W + 1)'(off);
      if (rr_sum > (ID_W + 1)'(N_REQ - 1)) rr_sum = rr_sum - (ID_W + 1)'(N_REQ - 1);
      rr_idx = rr_sum[ID_W-1:0];
      if (!gnt_any && req[rr_idx]) begin
        gnt_any = 1'b1;
        win_id  = rr_idx;
      end
    end
    if (!RST_N) gnt_any = 1'b0;
    gnt = gnt_any ? (N_REQ'(1) << win_id) : '0;
  end

  // Next-state for round-robin pointer, wait counters and registered read address.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    ram_addr_d = ram_addr_q;
    if (gnt_any && (win_id != '0)) begin
      rr_ptr_d = (win_id == ID_W'(N_REQ - 1)) ? ID_W'(1) : win_id + ID_W'(1);
    end
    for (int unsigned k = 1; k < N_REQ; k++) begin
      if (req[k] && !gnt[k]) begin
        wait_d[k] = (wait_q[k] == WAIT_SAT) ? wait_q[k] : wait_q[k] + CW'(1);
      end else begin
        wait_d[k] = '0;
      end
    end
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (gnt[k]) ram_addr_d = req_addr[k*ADDR_W +: ADDR_W];
    end
  end

  // Arbitration state registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rr_ptr_q   <= ID_W'(1);
      ram_addr_q <= '0;
      for (int unsigned k = 1; k < N_REQ; k++) wait_q[k] <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      ram_addr_q <= ram_addr_d;
      for (int unsigned k = 1; k < N_REQ; k++) wait_q[k] <= wait_d[k];
    end
  end

  // Read-tag pipeline: stage 0 is the RAM strobe, stage RAM_LAT lines up with ram_data.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i <= RAM_LAT; i++) begin
        pv_q[i]  <= 1'b0;
        pid_q[i] <= '0;
      end
    end else begin
      pv_q[0] <= gnt_any;
      if (gnt_any) pid_q[0] <= win_id;
      for (int unsigned i = 1; i <= RAM_LAT; i++) begin
        pv_q[i]  <= pv_q[i-1];
        pid_q[i] <= pid_q[i-1];
      end
    end
  end

  // Return stage: capture RAM data with its tag; id/data hold between returns.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_valid_q <= 1'b0;
      rd_id_q    <= '0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= pv_q[RAM_LAT];
      if (pv_q[RAM_LAT]) begin
        rd_id_q   <= pid_q[RAM_LAT];
        rd_data_q <= ram_data;
      end
    end
  end

  assign ram_rd   = pv_q[0];
  assign ram_addr = ram_addr_q;
  assign rd_valid = rd_valid_q;
  assign rd_id    = rd_id_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: directed scenarios followed by random traffic,
// checked against a cycle-level reference model of the arbitration rules.
module tb_sprite_rom_arbiter;

  localparam int N   = 9;
  localparam int IDW = 4;
  localparam int AW  = 11;
  localparam int DW  = 9;
  localparam int LAT = 1;
  localparam int MW  = 7;

  logic            CLK = 1'b0;
  logic            RST_N = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]    gnt;
  logic            ram_rd;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_data = '0;
  logic            rd_valid;
  logic [IDW-1:0]  rd_id;
  logic [DW-1:0]   rd_data;

  sprite_rom_arbiter #(
    .N_REQ(N), .ID_W(IDW), .ADDR_W(AW), .DATA_W(DW), .RAM_LAT(LAT), .MAX_WAIT(MW)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .req(req), .req_addr(req_addr), .gnt(gnt),
    .ram_rd(ram_rd), .ram_addr(ram_addr), .ram_data(ram_data),
    .rd_valid(rd_valid), .rd_id(rd_id), .rd_data(rd_data)
  );

  always #5 CLK = ~CLK;

  function automatic logic [DW-1:0] ram_f(input logic [AW-1:0] a);
    logic [AW-1:0] t;
    t = a * 11'd7 + (a >> 4);
    return t[DW-1:0] ^ 9'h0A5;
  endfunction

  // Single-cycle-latency sprite RAM.
  always @(posedge CLK) ram_data <= ram_f(ram_addr);

  typedef struct { int due; int id; logic [AW-1:0] addr; } ret_t;

  int            wt [N];
  int            rr;
  ret_t          q [$];
  logic          exp_rd;
  logic [AW-1:0] exp_addr;
  logic [31:0]   last_id;
  logic [31:0]   last_data;
  int            cyc;
  int            g_cur;
  int            vectors;
  int            miscompares;
  int            lastg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_addr(input int k, input logic [AW-1:0] v);
    req_addr[k*AW +: AW] = v;
  endtask

  function automatic int model_grant();
    for (int k = 1; k < N; k++)
      if (req[k] && wt[k] >= MW) return k;
    if (req[0]) return 0;
    for (int i = 0; i < N - 1; i++) begin
      int k;
      k = ((rr - 1 + i) % (N - 1)) + 1;
      if (req[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) wt[k] = 0;
    rr = 1;
    q.delete();
    exp_rd = 1'b0;
    exp_addr = '0;
    last_id = '0;
    last_data = '0;
    lastg = -1;
  endtask

  // Called at posedge+1 after inputs are set; checks all outputs of this cycle.
  task automatic sample();
    #3;
    g_cur = model_grant();
    chk("gnt", 32'(gnt), (g_cur >= 0) ? (32'd1 << g_cur) : 32'd0);
    chk("ram_rd", 32'(ram_rd), 32'(exp_rd));
    chk("ram_addr", 32'(ram_addr), 32'(exp_addr));
    if (q.size() > 0 && q[0].due == cyc) begin
      last_id = 32'(q[0].id);
      last_data = 32'(ram_f(q[0].addr));
      void'(q.pop_front());
      chk("rd_valid", 32'(rd_valid), 32'd1);
    end else begin
      chk("rd_valid", 32'(rd_valid), 32'd0);
    end
    chk("rd_id", 32'(rd_id), last_id);
    chk("rd_data", 32'(rd_data), last_data);
  endtask

  // Apply the clock edge to the model, then move to posedge+1.
  task automatic advance();
    for (int k = 1; k < N; k++) begin
      if (req[k] && g_cur != k) wt[k] = (wt[k] + 1 > MW) ? MW : wt[k] + 1;
      else wt[k] = 0;
    end
    if (g_cur >= 1) rr = (g_cur % (N - 1)) + 1;
    exp_rd = (g_cur >= 0);
    if (g_cur >= 0) begin
      exp_addr = req_addr[g_cur*AW +: AW];
      q.push_back('{cyc + 2 + LAT, g_cur, exp_addr});
    end
    lastg = g_cur;
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_ram_rd", 32'(ram_rd), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_id", 32'(rd_id), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    model_reset();
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    cyc = 0;
    g_cur = -1;
    model_reset();
    #1;
    do_reset();
    sample(); advance();

    // T2 single read
    set_addr(2, 11'h123);
    req = 9'h004;
    sample(); chk("T2_gnt", 32'(gnt), 32'h004); advance();
    req = '0;
    sample(); chk("T2_ram_rd", 32'(ram_rd), 32'd1); chk("T2_ram_addr", 32'(ram_addr), 32'h123); advance();
    sample(); advance();
    sample();
    chk("T2_rd_valid", 32'(rd_valid), 32'd1);
    chk("T2_rd_id", 32'(rd_id), 32'd2);
    chk("T2_rd_data", 32'(rd_data), 32'(ram_f(11'h123)));
    advance();

    // T1 reset with two reads in flight
    set_addr(3, 11'h055); req = 9'h008; sample(); advance();
    set_addr(4, 11'h2AA); req = 9'h010; sample(); advance();
    req = 9'h001;
    do_reset();
    req = '0;
    for (int i = 0; i < 5; i++) begin
      sample(); chk("T1_no_valid", 32'(rd_valid), 32'd0); advance();
    end

    // T5 wrap from rr_ptr=8, then idle
    set_addr(7, 11'h007); req = 9'h080; sample(); advance();
    req = '0; sample(); advance();
    set_addr(8, 11'h3C8); set_addr(1, 11'h111);
    req = 9'h102; sample(); chk("T5_gnt8", 32'(gnt), 32'h100); advance();
    req = 9'h002; sample(); chk("T5_gnt1", 32'(gnt), 32'h002); advance();
    req = '0;
    for (int i = 0; i < 6; i++) begin
      sample();
      if (i >= 3) begin
        chk("T5_idle_rd", 32'(ram_rd), 32'd0);
        chk("T5_idle_valid", 32'(rd_valid), 32'd0);
      end
      advance();
    end

    // T3 round-robin over 1..8 (pointer set to 1 by granting 8 first)
    req = 9'h100; sample(); advance();
    for (int k = 1; k < N; k++) set_addr(k, AW'(k * 16 + 3));
    req = 9'h1FE;
    for (int i = 0; i < 10; i++) begin
      sample(); chk("T3_order", 32'(gnt), 32'd1 << ((i % 8) + 1)); advance();
    end
    req = '0;
    for (int i = 0; i < 4; i++) begin sample(); advance(); end

    // T4 priority 0 versus starvation of 5
    set_addr(0, 11'h600); set_addr(5, 11'h505);
    req = 9'h021;
    for (int i = 0; i < 10; i++) begin
      sample(); chk("T4_gnt", 32'(gnt), (i == 7) ? 32'h020 : 32'h001); advance();
    end
    req = '0;
    for (int i = 0; i < 4; i++) begin sample(); advance(); end

    // Random traffic with one mid-run reset
    for (int c = 0; c < 400; c++) begin
      if (c == 200) begin
        do_reset();
      end
      for (int k = 0; k < N; k++) begin
        if (k == lastg) begin
          if ($urandom_range(1, 0) == 1) req[k] = 1'b0;
          else set_addr(k, AW'($urandom));
        end else if (!req[k]) begin
          if ($urandom_range(99, 0) < ((k == 0) ? 15 : 25)) begin
            req[k] = 1'b1;
            set_addr(k, AW'($urandom));
          end
        end else if ($urandom_range(99, 0) < 10) begin
          set_addr(k, AW'($urandom));
        end
      end
      sample(); advance();
    end
    req = '0;
    for (int i = 0; i < 6; i++) begin sample(); advance(); end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
